// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared pixel constants, stage-1 record and helpers for the edge pipeline
package edge_pkg;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  // Input-to-output delay; downstream stages align their markers to this.
  localparam int EDGE_LAT = 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t cur;
    pix_t left;
    logic lv;
    logic tv;
    logic pix;
  } s1_t;

  function automatic pix_t abs_diff(input pix_t a, input pix_t b);
    return (a >= b) ? pix_t'(a - b) : pix_t'(b - a);
  endfunction

endpackage

// File: rtl/edge_detect_if.sv
// rtl/edge_detect_if.sv - pixel stream with frame/line markers, in and out of the edge detector
interface edge_detect_if;
  import edge_pkg::*;

  pix_t PixelIn;
  logic FrameIn;
  logic LineIn;
  pix_t PixelOut;
  logic FrameOut;
  logic LineOut;

  modport master (
    output PixelIn, FrameIn, LineIn,
    input  PixelOut, FrameOut, LineOut
  );

  modport slave (
    input  PixelIn, FrameIn, LineIn,
    output PixelOut, FrameOut, LineOut
  );

endinterface

// File: rtl/edge_line_buf.sv
// rtl/edge_line_buf.sv - single-port previous-row buffer, synchronous read-before-write
module edge_line_buf
  import edge_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];
  pix_t rdata_q;

  // No reset so the array maps onto block RAM; the read returns the old word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - two-stage gradient edge detector on a marker-framed greyscale stream
// EDGE_GRAD_OUT_EN: output the saturated gradient magnitude instead of the binarised edge
module edge_detect
  import edge_pkg::*;
#(
  parameter int MAX_WIDTH = 256,
  parameter int XW        = 8
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [PIX_W-1:0] Threshold,
  edge_detect_if.slave     bus
);

  localparam logic [XW-1:0] X_LAST = XW'(MAX_WIDTH - 1);

  logic pix_cyc;
  assign pix_cyc = ~bus.FrameIn & ~bus.LineIn;

  logic [XW-1:0] x_q, x_d;
  logic          ovf_q, ovf_d;
  logic          top_valid_q, top_valid_d;
  logic          left_valid_q, left_valid_d;
  pix_t          prev_q, prev_d;

  // ovf marks pixel indices past the buffer; x then stays parked at X_LAST.
  always_comb begin
    x_d          = x_q;
    ovf_d        = ovf_q;
    top_valid_d  = top_valid_q;
    left_valid_d = left_valid_q;
    prev_d       = prev_q;
    if (bus.FrameIn) begin
      x_d          = '0;
      ovf_d        = 1'b0;
      left_valid_d = 1'b0;
      top_valid_d  = 1'b0;
    end else if (bus.LineIn) begin
      x_d          = '0;
      ovf_d        = 1'b0;
      left_valid_d = 1'b0;
      top_valid_d  = 1'b1;
    end else begin
      left_valid_d = 1'b1;
      prev_d       = bus.PixelIn;
      if (x_q == X_LAST) begin
        ovf_d = 1'b1;
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  s1_t s1_q, s1_d;

  always_comb begin
    s1_d     = s1_q;
    s1_d.pix = pix_cyc;
    if (pix_cyc) begin
      s1_d.cur  = bus.PixelIn;
      s1_d.left = prev_q;
      s1_d.lv   = left_valid_q;
      s1_d.tv   = top_valid_q & ~ovf_q;
    end
  end

  pix_t top_rd;

  edge_line_buf #(
    .DEPTH (MAX_WIDTH),
    .AW    (XW)
  ) u_line_buf (
    .clk   (Clk),
    .en    (nReset & pix_cyc),
    .we    (~ovf_q),
    .addr  (x_q),
    .wdata (bus.PixelIn),
    .rdata (top_rd)
  );

  pix_t           dx, dy, pix_out_d, pix_out_q;
  logic [PIX_W:0] sum;

  always_comb begin
    dx  = s1_q.lv ? abs_diff(s1_q.cur, s1_q.left) : '0;
    dy  = s1_q.tv ? abs_diff(s1_q.cur, top_rd) : '0;
    sum = {1'b0, dx} + {1'b0, dy};
`ifdef EDGE_GRAD_OUT_EN
    pix_out_d = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
`else
    pix_out_d = (sum > {1'b0, Threshold}) ? EDGE_ON : EDGE_OFF;
`endif
    if (!s1_q.pix) begin
      pix_out_d = EDGE_OFF;
    end
  end

  logic [EDGE_LAT-1:0] frame_sr_q, line_sr_q;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      x_q          <= '0;
      ovf_q        <= 1'b0;
      top_valid_q  <= 1'b0;
      left_valid_q <= 1'b0;
      prev_q       <= '0;
      s1_q         <= '0;
      pix_out_q    <= EDGE_OFF;
      frame_sr_q   <= '0;
      line_sr_q    <= '0;
    end else begin
      x_q          <= x_d;
      ovf_q        <= ovf_d;
      top_valid_q  <= top_valid_d;
      left_valid_q <= left_valid_d;
      prev_q       <= prev_d;
      s1_q         <= s1_d;
      pix_out_q    <= pix_out_d;
      frame_sr_q   <= {frame_sr_q[EDGE_LAT-2:0], bus.FrameIn};
      line_sr_q    <= {line_sr_q[EDGE_LAT-2:0], bus.LineIn};
    end
  end

  assign bus.PixelOut = pix_out_q;
  assign bus.FrameOut = frame_sr_q[EDGE_LAT-1];
  assign bus.LineOut  = line_sr_q[EDGE_LAT-1];

endmodule

// File: doc/edge_detect.md
Name: edge_detect

Overview:
- Pixel-stream edge detector that sits directly upstream of the line-overlay stage.
- Consumes the raw 8-bit greyscale stream with FrameIn/LineIn markers.
- Produces a binarised edge stream (0xFF edge, 0x00 background) on the same marker protocol, ready for the overlay/Hough stages.
- Gradient is |P(x,y)-P(x-1,y)| + |P(x,y)-P(x,y-1)|; the previous row is held in a single line buffer.

Parameters:
MAX_WIDTH, 256, maximum pixels per line held in the line buffer
XW, 8, width of the x counter and line-buffer address (clog2(MAX_WIDTH))

Ports:
Clk  input  1  clock, all logic on rising edge
nReset  input  1  synchronous active-low reset, sampled on rising Clk
PixelIn  input  8  input pixel; valid on every cycle where FrameIn=0 and LineIn=0
FrameIn  input  1  single-cycle start-of-frame marker; carries no pixel
LineIn  input  1  single-cycle start-of-line marker; carries no pixel
Threshold  input  8  edge threshold, quasi-static; sampled in stage 2
PixelOut  output  8  edge pixel (0xFF/0x00), or magnitude when the optional feature is enabled
FrameOut  output  1  FrameIn delayed 2 cycles
LineOut  output  1  LineIn delayed 2 cycles

Behaviour:
- Reset (nReset=0 at posedge):
  - PixelOut=0x00, FrameOut=0, LineOut=0.
  - x=0, top_valid=0, left_valid=0, all pipeline registers cleared.
  - Line-buffer RAM contents are not cleared; they are ignored while top_valid=0.
- Coordinate tracking, one update per cycle:
  - FrameIn=1: x<=0, left_valid<=0, top_valid<=0. FrameIn has priority over a simultaneous LineIn.
  - LineIn=1 (FrameIn=0): x<=0, left_valid<=0, top_valid<=1.
  - Pixel cycle: x<=x+1, saturating at MAX_WIDTH-1; left_valid<=1.
- Stage 1, on a pixel cycle:
  - Register PixelIn as cur.
  - Register the previous pixel as left.
  - Read line buffer at address x into top. Read-before-write: the same-cycle write is not visible.
  - Write PixelIn to the buffer at x. The write is suppressed once x has saturated (pixel index >= MAX_WIDTH).
  - Register valid flags: lv=left_valid; tv=top_valid and (x < MAX_WIDTH).
- Stage 2:
  - dx = lv ? |cur-left| : 0; dy = tv ? |cur-top| : 0. Each term is 8 bits unsigned.
  - sum = dx+dy, 9 bits, no overflow.
  - PixelOut = (sum > {1'b0,Threshold}) ? 0xFF : 0x00.
- Latency: exactly 2 cycles from input to output for pixels and for markers.
  - Output cycles corresponding to marker input cycles carry PixelOut=0x00.
- Boundaries:
  - First row after FrameIn: vertical term is 0.
  - Column 0: horizontal term is 0.
  - A line shorter than the previous one leaves stale buffer entries beyond its end; these are harmless.
  - A line longer than MAX_WIDTH: pixels past the limit use dx only.
- Reset mid-frame: the pipeline drains to zeros, and the first output after reset release follows the 2-cycle latency with top_valid=0 until the next LineIn.
- Threshold=0xFF: sum max is 510, so strong edges are still detected.

Optional Feature:
- EDGE_GRAD_OUT_EN defined:
  - PixelOut = min(sum,255), the saturated gradient magnitude.
  - Threshold is unused and compare logic is omitted.
- Not defined: binarised output as above.

Decomposition:
- Shared package edge_pkg:
  - PIX_W=8, EDGE_ON=8'hFF, EDGE_OFF=8'h00.
  - Pipeline latency constant EDGE_LAT=2, reused by downstream stages for marker alignment.
- One sub-module, edge_line_buf:
  - MAX_WIDTH x 8 single-port RAM with synchronous read-before-write and a write enable.
  - Maps to block RAM.

Test Plan:
- Flat image (all pixels 0x40, 4 lines x 8 px, Threshold=0x10) -> every PixelOut=0x00; FrameOut/LineOut equal the inputs delayed exactly 2 cycles.
- Vertical step (pixels x<4 =0x00, x>=4 =0x80, Threshold=0x40) -> PixelOut=0xFF only at x=4 in every line, 0x00 elsewhere.
- Horizontal step (row 0 =0x10, row 1 =0x90, Threshold=0x40) -> row 0 all 0x00 (no top); row 1 all 0xFF.
- Combined: cur=0x80, left=0x40, top=0x40, Threshold=0x7F -> sum=0x80 gives 0xFF; same with Threshold=0x80 gives 0x00 (strict >).
- FrameIn and LineIn asserted together mid-frame -> treated as FrameIn: the next row gets no vertical term; FrameOut=1 and LineOut=1 two cycles later.
- nReset pulsed low for 1 cycle mid-line -> outputs 0 the following cycle, no stale edges; with EDGE_GRAD_OUT_EN, cur=0xFF, left=0x00, top=0x00 gives PixelOut=0xFF (saturated from 510).
